// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes,
// funct codes, ALU-op classes, ALU control values and the per-state control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  // alu_en marks states that actually drive the ALU; alucontrol is zero elsewhere.
  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       alu_en;
    aluop_e     aluop;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t alu_cfg(input logic srca, input logic [1:0] srcb,
                                    input aluop_e aluop);
    ctrl_t c;
    c         = '0;
    c.alusrca = srca;
    c.alusrcb = srcb;
    c.aluop   = aluop;
    c.alu_en  = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU control decode from ALU-op class and funct; purely combinational.
// funct_bad flags an unrecognised funct regardless of aluop so the FSM can qualify it.
module mc_alu_dec
  import mips_ctrl_pkg::*;
#(
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3
) (
  input  aluop_e               aluop,
  input  logic [FUNCT_W-1:0]   funct,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 funct_bad
);

  logic [2:0] funct_ctl;
  logic [2:0] ctl;

  always_comb begin
    funct_ctl = ALUC_ADD;
    funct_bad = 1'b0;
    case (funct)
      FUNCT_W'(FN_ADD): funct_ctl = ALUC_ADD;
      FUNCT_W'(FN_SUB): funct_ctl = ALUC_SUB;
      FUNCT_W'(FN_AND): funct_ctl = ALUC_AND;
      FUNCT_W'(FN_OR):  funct_ctl = ALUC_OR;
      FUNCT_W'(FN_SLT): funct_ctl = ALUC_SLT;
      default:          funct_bad = 1'b1;
    endcase
  end

  always_comb begin
    ctl = ALUC_ADD;
    case (aluop)
      ALUOP_ADD:   ctl = ALUC_ADD;
      ALUOP_SUB:   ctl = ALUC_SUB;
      ALUOP_FUNCT: ctl = funct_ctl;
      default:     ctl = ALUC_ADD;
    endcase
  end

  assign alucontrol = ALUCTRL_W'(ctl);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM; outputs are combinational from state and inputs,
// FETCH/MEMRD/MEMWR hold while mem_ready is low, and everything reads zero in reset.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W      = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3,
  parameter int BNE_EN    = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal
);

  localparam logic BNE_ON = (BNE_EN != 0);

  state_e state_q, state_d;
  logic   is_bne_q, is_bne_d;
  ctrl_t  ctrl, ctrl_g;
  logic   funct_bad;
  logic [ALUCTRL_W-1:0] dec_ctl;

  logic is_lw, is_sw, is_r, is_beq, is_bne, is_addi, is_j, op_known;

  assign is_lw    = (op == OP_W'(OP_LW));
  assign is_sw    = (op == OP_W'(OP_SW));
  assign is_r     = (op == OP_W'(OP_RTYPE));
  assign is_beq   = (op == OP_W'(OP_BEQ));
  assign is_bne   = BNE_ON && (op == OP_W'(OP_BNE));
  assign is_addi  = (op == OP_W'(OP_ADDI));
  assign is_j     = (op == OP_W'(OP_J));
  assign op_known = is_lw | is_sw | is_r | is_beq | is_bne | is_addi | is_j;

  // The branch sense is captured in DECODE so op may change freely in BRANCH.
  assign is_bne_d = (state_q == DECODE) ? is_bne : is_bne_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= FETCH;
      is_bne_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_bne_q <= is_bne_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        if (is_lw || is_sw)       state_d = MEMADR;
        else if (is_r)            state_d = EXECUTE;
        else if (is_beq || is_bne) state_d = BRANCH;
        else if (is_addi)         state_d = ADDIEXEC;
        else if (is_j)            state_d = JUMP;
        else                      state_d = FETCH;
      end
      MEMADR:   state_d = is_sw ? MEMWR : MEMRD;
      MEMRD:    if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWR:    if (mem_ready) state_d = FETCH;
      EXECUTE:  state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      BRANCH:   state_d = FETCH;
      ADDIEXEC: state_d = ADDIWB;
      ADDIWB:   state_d = FETCH;
      JUMP:     state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    unique case (state_q)
      FETCH: begin
        ctrl         = alu_cfg(1'b0, 2'b01, ALUOP_ADD);
        ctrl.mem_req = 1'b1;
        ctrl.irwrite = mem_ready;
        ctrl.pcwrite = mem_ready;
      end
      DECODE: begin
        ctrl         = alu_cfg(1'b0, 2'b11, ALUOP_ADD);
        ctrl.illegal = ~op_known;
      end
      MEMADR:   ctrl = alu_cfg(1'b1, 2'b10, ALUOP_ADD);
      MEMRD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req  = 1'b1;
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl         = alu_cfg(1'b1, 2'b00, ALUOP_FUNCT);
        ctrl.illegal = funct_bad;
      end
      ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      BRANCH: begin
        ctrl        = alu_cfg(1'b1, 2'b00, ALUOP_SUB);
        ctrl.pcsrc  = 2'b01;
        ctrl.branch = 1'b1;
      end
      ADDIEXEC: ctrl = alu_cfg(1'b1, 2'b10, ALUOP_ADD);
      ADDIWB:   ctrl.regwrite = 1'b1;
      JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
      end
      default:  ctrl = '0;
    endcase
  end

  // Reset masks the whole control word, so an in-flight access drops immediately.
  assign ctrl_g = resetn ? ctrl : '0;

  mc_alu_dec #(
    .FUNCT_W   (FUNCT_W),
    .ALUCTRL_W (ALUCTRL_W)
  ) u_alu_dec (
    .aluop      (ctrl_g.aluop),
    .funct      (funct),
    .alucontrol (dec_ctl),
    .funct_bad  (funct_bad)
  );

  assign mem_req    = ctrl_g.mem_req;
  assign iord       = ctrl_g.iord;
  assign memwrite   = ctrl_g.memwrite;
  assign irwrite    = ctrl_g.irwrite;
  assign regwrite   = ctrl_g.regwrite;
  assign regdst     = ctrl_g.regdst;
  assign memtoreg   = ctrl_g.memtoreg;
  assign alusrca    = ctrl_g.alusrca;
  assign alusrcb    = ctrl_g.alusrcb;
  assign pcsrc      = ctrl_g.pcsrc;
  assign pcen       = ctrl_g.pcwrite | (ctrl_g.branch & (zero ^ is_bne_q));
  assign alucontrol = ctrl_g.alu_en ? dec_ctl : '0;
  assign illegal    = ctrl_g.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: one default instance and one with bne enabled,
// driven in lockstep, outputs compared against hand-computed control words.
module tb_multicycle_controller;
  import mips_ctrl_pkg::*;

  logic       clk;
  logic       resetn;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, pcen, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  logic       mem_req_b, iord_b, memwrite_b, irwrite_b, regwrite_b, regdst_b, memtoreg_b;
  logic       alusrca_b, pcen_b, illegal_b;
  logic [1:0] alusrcb_b, pcsrc_b;
  logic [2:0] alucontrol_b;

  logic [16:0] outv;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_controller dut (
    .clk(clk), .resetn(resetn), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol), .illegal(illegal)
  );

  multicycle_controller #(.BNE_EN(1)) dut_b (
    .clk(clk), .resetn(resetn), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .iord(iord_b), .memwrite(memwrite_b), .irwrite(irwrite_b),
    .regwrite(regwrite_b), .regdst(regdst_b), .memtoreg(memtoreg_b), .alusrca(alusrca_b),
    .alusrcb(alusrcb_b), .pcsrc(pcsrc_b), .pcen(pcen_b), .alucontrol(alucontrol_b),
    .illegal(illegal_b)
  );

  // {mem_req,iord,memwrite,irwrite,regwrite,regdst,memtoreg,alusrca,alusrcb,pcsrc,pcen,alucontrol,illegal}
  assign outv = {mem_req, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal};

  localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_0_0_0_01_00_1_010_0;
  localparam logic [16:0] E_FSTALL = 17'b1_0_0_0_0_0_0_0_01_00_0_010_0;
  localparam logic [16:0] E_DEC    = 17'b0_0_0_0_0_0_0_0_11_00_0_010_0;
  localparam logic [16:0] E_DECILL = 17'b0_0_0_0_0_0_0_0_11_00_0_010_1;
  localparam logic [16:0] E_MADR   = 17'b0_0_0_0_0_0_0_1_10_00_0_010_0;
  localparam logic [16:0] E_MRD    = 17'b1_1_0_0_0_0_0_0_00_00_0_000_0;
  localparam logic [16:0] E_MWB    = 17'b0_0_0_0_1_0_1_0_00_00_0_000_0;
  localparam logic [16:0] E_MWR    = 17'b1_1_1_0_0_0_0_0_00_00_0_000_0;
  localparam logic [16:0] E_AWB    = 17'b0_0_0_0_1_1_0_0_00_00_0_000_0;
  localparam logic [16:0] E_BR1    = 17'b0_0_0_0_0_0_0_1_00_01_1_110_0;
  localparam logic [16:0] E_BR0    = 17'b0_0_0_0_0_0_0_1_00_01_0_110_0;
  localparam logic [16:0] E_IWB    = 17'b0_0_0_0_1_0_0_0_00_00_0_000_0;
  localparam logic [16:0] E_JMP    = 17'b0_0_0_0_0_0_0_0_00_10_1_000_0;

  // R-type table: funct, expected EXECUTE control word
  logic [5:0]  fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
  logic [16:0] fn_exp  [6] = '{17'b0_0_0_0_0_0_0_1_00_00_0_010_0,
                               17'b0_0_0_0_0_0_0_1_00_00_0_110_0,
                               17'b0_0_0_0_0_0_0_1_00_00_0_000_0,
                               17'b0_0_0_0_0_0_0_1_00_00_0_001_0,
                               17'b0_0_0_0_0_0_0_1_00_00_0_111_0,
                               17'b0_0_0_0_0_0_0_1_00_00_0_010_1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [16:0] exp, input state_e st);
    #1;
    chk({tag, "_out"}, 32'(outv), 32'(exp));
    chk({tag, "_st"}, 32'(dut.state_q), 32'(st));
    tick();
  endtask

  initial begin
    resetn = 1'b0; op = OP_LW; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    chk("rst_out", 32'(outv), 32'd0);
    chk("rst_pcen_b", 32'(pcen_b), 32'd0);
    chk("rst_st", 32'(dut.state_q), 32'(FETCH));
    resetn = 1'b1;

    // lw: 5 cycles, write-back only in the last
    op = OP_LW;
    cyc("lw_fetch", E_FETCH, FETCH);
    cyc("lw_dec", E_DEC, DECODE);
    cyc("lw_madr", E_MADR, MEMADR);
    cyc("lw_mrd", E_MRD, MEMRD);
    cyc("lw_mwb", E_MWB, MEMWB);

    // sw: 4 cycles
    op = OP_SW;
    cyc("sw_fetch", E_FETCH, FETCH);
    cyc("sw_dec", E_DEC, DECODE);
    cyc("sw_madr", E_MADR, MEMADR);
    cyc("sw_mwr", E_MWR, MEMWR);

    // R-type over the funct table; op disturbed after DECODE must not matter
    for (int i = 0; i < 6; i++) begin
      op = OP_RTYPE; funct = fn_tab[i];
      cyc("r_fetch", E_FETCH, FETCH);
      cyc("r_dec", E_DEC, DECODE);
      op = OP_LW;
      cyc($sformatf("r_exec%0d", i), fn_exp[i], EXECUTE);
      cyc("r_awb", E_AWB, ALUWB);
    end

    // beq taken / not taken
    op = OP_BEQ; zero = 1'b1;
    cyc("beq1_fetch", E_FETCH, FETCH);
    cyc("beq1_dec", E_DEC, DECODE);
    #1; chk("beq1_pcen_b", 32'(pcen_b), 32'd1);
    cyc("beq1_br", E_BR1, BRANCH);
    zero = 1'b0;
    cyc("beq0_fetch", E_FETCH, FETCH);
    cyc("beq0_dec", E_DEC, DECODE);
    cyc("beq0_br", E_BR0, BRANCH);

    // bne: illegal on the default build, inverted branch on the enabled build
    for (int z = 0; z < 2; z++) begin
      op = OP_BNE; zero = 1'(z);
      cyc("bne_fetch", E_FETCH, FETCH);
      #1;
      chk("bne_dec_a", 32'(outv), 32'(E_DECILL));
      chk("bne_dec_ill_b", 32'(illegal_b), 32'd0);
      chk("bne_dec_st_b", 32'(dut_b.state_q), 32'(DECODE));
      tick();
      op = OP_BEQ;
      #1;
      chk("bne_br_pcen_b", 32'(pcen_b), 32'(1 - z));
      chk("bne_br_pcsrc_b", 32'(pcsrc_b), 32'd1);
      chk("bne_br_st_b", 32'(dut_b.state_q), 32'(BRANCH));
      chk("bne_st_a", 32'(dut.state_q), 32'(FETCH));
      resetn = 1'b0;
      #1;
      chk("bne_rst_out", 32'(outv), 32'd0);
      chk("bne_rst_pcen_b", 32'(pcen_b), 32'd0);
      tick();
      resetn = 1'b1;
    end
    zero = 1'b0;

    // addi and j
    op = OP_ADDI;
    cyc("addi_fetch", E_FETCH, FETCH);
    cyc("addi_dec", E_DEC, DECODE);
    cyc("addi_exec", E_MADR, ADDIEXEC);
    cyc("addi_wb", E_IWB, ADDIWB);
    op = OP_J;
    cyc("j_fetch", E_FETCH, FETCH);
    cyc("j_dec", E_DEC, DECODE);
    cyc("j_jump", E_JMP, JUMP);

    // three-cycle FETCH stall, then the jump completes
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("stall_fetch", E_FSTALL, FETCH);
    mem_ready = 1'b1;
    cyc("stall_go", E_FETCH, FETCH);
    cyc("stall_dec", E_DEC, DECODE);
    cyc("stall_jump", E_JMP, JUMP);

    // unknown opcode: one-cycle illegal pulse, back to FETCH
    op = 6'b111111;
    cyc("ill_fetch", E_FETCH, FETCH);
    cyc("ill_dec", E_DECILL, DECODE);
    op = OP_J;
    cyc("ill_back", E_FETCH, FETCH);
    cyc("ill_jdec", E_DEC, DECODE);
    cyc("ill_jump", E_JMP, JUMP);

    // lw with one MEMRD wait cycle
    op = OP_LW;
    cyc("lws_fetch", E_FETCH, FETCH);
    cyc("lws_dec", E_DEC, DECODE);
    cyc("lws_madr", E_MADR, MEMADR);
    mem_ready = 1'b0;
    cyc("lws_mrd_wait", E_MRD, MEMRD);
    mem_ready = 1'b1;
    cyc("lws_mrd", E_MRD, MEMRD);
    cyc("lws_mwb", E_MWB, MEMWB);

    // sw stalled in MEMWR, op disturbed, then reset mid-access
    op = OP_SW;
    cyc("swr_fetch", E_FETCH, FETCH);
    cyc("swr_dec", E_DEC, DECODE);
    cyc("swr_madr", E_MADR, MEMADR);
    op = OP_RTYPE; mem_ready = 1'b0;
    cyc("swr_mwr0", E_MWR, MEMWR);
    cyc("swr_mwr1", E_MWR, MEMWR);
    resetn = 1'b0;
    #1;
    chk("swr_rst_memwrite", 32'(memwrite), 32'd0);
    chk("swr_rst_out", 32'(outv), 32'd0);
    tick();
    chk("swr_rst_st", 32'(dut.state_q), 32'(FETCH));
    resetn = 1'b1; mem_ready = 1'b1; op = OP_J;
    cyc("post_rst_fetch", E_FETCH, FETCH);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter OP_W, default 6, meaning opcode width.
REQ-002 The block SHALL have parameter FUNCT_W, default 6, meaning funct width.
REQ-003 The block SHALL have parameter ALUCTRL_W, default 3, meaning alucontrol width.
REQ-004 The block SHALL have parameter BNE_EN, default 0, meaning 1 enables bne (op 000101) decode.
REQ-005 The block SHALL use one clock and a synchronous, active-low reset, with ports: clk in 1, rising-edge clock; resetn in 1, synchronous active-low reset.
REQ-006 Ports SHALL be: op in OP_W; funct in FUNCT_W; zero in 1, ALU zero flag; mem_ready in 1, memory completes access this cycle.
REQ-007 Outputs SHALL be: mem_req 1; iord 1; memwrite 1; irwrite 1; regwrite 1; regdst 1; memtoreg 1; alusrca 1; alusrcb 2; pcsrc 2; pcen 1; alucontrol ALUCTRL_W; illegal 1, one-cycle unknown-opcode pulse.

Function
REQ-008 The FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP.
REQ-009 FETCH SHALL assert mem_req, iord=0, alusrca=0, alusrcb=01, aluop=add, pcsrc=00; irwrite and pcwrite only when mem_ready=1; stay in FETCH while mem_ready=0, go to DECODE when 1.
REQ-010 DECODE SHALL drive alusrca=0, alusrcb=11, aluop=add, then go by op: lw(100011)/sw(101011) -> MEMADR; R-type(000000) -> EXECUTE; beq(000100), and bne when BNE_EN=1 -> BRANCH; addi(001000) -> ADDIEXEC; j(000010) -> JUMP; any other op -> FETCH with illegal=1 for that cycle.
REQ-011 MEMADR SHALL drive alusrca=1, alusrcb=10, aluop=add, then go to MEMRD (lw) or MEMWR (sw).
REQ-012 MEMRD SHALL drive mem_req=1, iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-013 MEMWB SHALL drive regwrite=1, memtoreg=1, regdst=0, then go to FETCH.
REQ-014 MEMWR SHALL drive mem_req=1, iord=1, memwrite=1; hold until mem_ready=1, then go to FETCH.
REQ-015 EXECUTE SHALL drive alusrca=1, alusrcb=00, aluop=funct, then go to ALUWB; ALUWB SHALL drive regwrite=1, regdst=1, memtoreg=0, then go to FETCH.
REQ-016 BRANCH SHALL drive alusrca=1, alusrcb=00, aluop=sub, pcsrc=01, branch=1; pcen = pcwrite | (branch & (zero XOR is_bne)); then go to FETCH.
REQ-017 ADDIEXEC SHALL drive alusrca=1, alusrcb=10, aluop=add; ADDIWB SHALL drive regwrite=1, regdst=0, memtoreg=0; then go to FETCH.
REQ-018 JUMP SHALL drive pcsrc=10, pcwrite=1, then go to FETCH.
REQ-019 alucontrol SHALL be add=010, sub=110; funct mapping: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; unknown funct SHALL give 010 and assert illegal in EXECUTE.
REQ-020 Latency with mem_ready tied 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles; each mem_ready=0 cycle in FETCH, MEMRD or MEMWR SHALL add one cycle.
REQ-021 Outputs SHALL be combinational from state plus op, funct, zero and mem_ready; every output not named for a state SHALL be 0.
REQ-022 op SHALL be sampled only in DECODE and MEMADR; op changes in other states SHALL have no effect.

Reset
REQ-023 resetn=0 at a rising clk edge SHALL set state=FETCH, from any state including MEMRD or MEMWR mid-access.
REQ-024 While resetn=0 all outputs SHALL be forced to 0, including mem_req, memwrite, pcen and illegal.

Structure
REQ-025 State encodings, opcode/funct constants, aluop encoding (add=00, sub=01, funct=10) and alucontrol values SHALL live in shared package mips_ctrl_pkg.
REQ-026 The funct/aluop to alucontrol decode SHALL be one sub-module, mc_alu_dec; the FSM SHALL stay in multicycle_controller.

Verification
REQ-027 lw (op 100011), mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 and memtoreg=1 only in cycle 5.
REQ-028 R-type funct 100010 -> alucontrol=110 in EXECUTE; regwrite=1, regdst=1 in ALUWB; back in FETCH on cycle 5.
REQ-029 beq with zero=1 in BRANCH -> pcen=1, pcsrc=01; zero=0 -> pcen=0; with BNE_EN=1 and op 000101 the result is inverted.
REQ-030 Hold mem_ready=0 for 3 cycles in FETCH -> irwrite=0, pcen=0 and state FETCH for those cycles; irwrite=1 on the 4th cycle, with mem_ready=1.
REQ-031 op 111111 -> illegal=1 for exactly the DECODE cycle, then FETCH; no regwrite or memwrite asserted.
REQ-032 sw in MEMWR with mem_ready=0, resetn=0 for one cycle -> memwrite=0 immediately; state FETCH after the edge.
